// File: rtl/serial_tx_pw.sv
// serial_tx_pw: pulse-width-encoded serial transmitter with req/busy/ack handshake.
// Define SERIAL_TX_PW_GAP_EN to add the ngap port and an idle GAP state after the last bit.
module serial_tx_pw #(
  parameter int DATA_W = 256,
  parameter int NBITS_W = 9,
  parameter int CNT_W = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [DATA_W-1:0]  data,
  input  logic [NBITS_W-1:0] nbits,
  input  logic [CNT_W-1:0]   n0,
  input  logic [CNT_W-1:0]   n1,
  input  logic [CNT_W-1:0]   nper,
  input  logic               y0,
`ifdef SERIAL_TX_PW_GAP_EN
  input  logic [CNT_W-1:0]   ngap,
`endif
  output logic               busy,
  output logic               ack,
  output logic               y
);
  localparam int IW = $clog2(DATA_W);
`ifdef SERIAL_TX_PW_GAP_EN
  typedef enum logic [1:0] {IDLE, BIT, DONE, GAP} state_t;
  logic [CNT_W-1:0] ng_l, ng_n;
`else
  typedef enum logic [1:0] {IDLE, BIT, DONE} state_t;
`endif
  state_t st, st_n;
  logic [DATA_W-1:0] data_l, data_n;
  logic [NBITS_W-1:0] nb_l, nb_n, idx, idx_n;
  logic [CNT_W-1:0] n0_l, n0_n, n1_l, n1_n, np_l, np_n, c, c_n, w;
  logic y0_l, y0_n, y_n;
  logic [IW-1:0] pos;
  always_comb begin
    st_n = st;
    data_n = data_l;
    nb_n = nb_l;
    n0_n = n0_l;
    n1_n = n1_l;
    np_n = np_l;
    y0_n = y0_l;
    idx_n = idx;
    c_n = c;
`ifdef SERIAL_TX_PW_GAP_EN
    ng_n = ng_l;
`endif
    case (st)
      IDLE: if (req) begin
        data_n = data;
        nb_n = nbits > NBITS_W'(DATA_W) ? NBITS_W'(DATA_W) : nbits;
        n0_n = n0;
        n1_n = n1;
        np_n = nper == '0 ? CNT_W'(1) : nper;
        y0_n = y0;
`ifdef SERIAL_TX_PW_GAP_EN
        ng_n = ngap;
`endif
        idx_n = '0;
        c_n = '0;
        st_n = nb_n == '0 ? DONE : BIT;
      end
      BIT: if (c != np_l - CNT_W'(1)) c_n = c + CNT_W'(1);
      else begin
        c_n = '0;
        idx_n = idx + NBITS_W'(1);
`ifdef SERIAL_TX_PW_GAP_EN
        if (idx == nb_l - NBITS_W'(1)) st_n = ng_l == '0 ? DONE : GAP;
`else
        if (idx == nb_l - NBITS_W'(1)) st_n = DONE;
`endif
      end
`ifdef SERIAL_TX_PW_GAP_EN
      GAP: begin
        c_n = c + CNT_W'(1);
        if (c == ng_l - CNT_W'(1)) st_n = DONE;
      end
`endif
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  // y is registered from the next-state view so bit 0 shows right after the accepting edge
  assign pos = MSB_FIRST != 0 ? IW'(nb_n - NBITS_W'(1) - idx_n) : IW'(idx_n);
  assign w = data_n[pos] ? n1_n : n0_n;
  assign y_n = st_n == BIT ? (c_n < w ? ~y0_n : y0_n) : st_n == IDLE ? y0 : y0_n;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      y <= y0;
    end else begin
      st <= st_n;
      y <= y_n;
    end
    data_l <= data_n;
    nb_l <= nb_n;
    n0_l <= n0_n;
    n1_l <= n1_n;
    np_l <= np_n;
    y0_l <= y0_n;
    idx <= idx_n;
    c <= c_n;
`ifdef SERIAL_TX_PW_GAP_EN
    ng_l <= ng_n;
`endif
  end
  assign busy = st != IDLE;
  assign ack = st == DONE;
endmodule
